// File: rtl/run_sequencer_if.sv
// ============================================================================
// Module      : run_sequencer_if
// Description : Bench handshake and core-control bundle for run_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface run_sequencer_if #(
    parameter int D  = 10,
    parameter int RF = 16,
    parameter int W  = 16
);
    localparam int AW = (RF > 1) ? $clog2(RF) : 1;

    logic          req;
    logic          halt;
    logic [D-1:0]  prog_ctr;
    logic          core_rst;
    logic          run_en;
    logic          rf_clr_en;
    logic [AW-1:0] rf_clr_addr;
    logic          done;
    logic          timeout;
    logic [W-1:0]  cycle_cnt;
    logic [D-1:0]  halt_pc;

    modport master (
        output req, halt, prog_ctr,
        input  core_rst, run_en, rf_clr_en, rf_clr_addr,
        input  done, timeout, cycle_cnt, halt_pc
    );

    modport slave (
        input  req, halt, prog_ctr,
        output core_rst, run_en, rf_clr_en, rf_clr_addr,
        output done, timeout, cycle_cnt, halt_pc
    );
endinterface

`default_nettype wire

// File: rtl/run_sequencer.sv
// ============================================================================
// Module      : run_sequencer
// Description : Run controller: clears the register file, runs the core until
//               halt or watchdog, then reports done / cycle count / halt PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_sequencer #(
    parameter int D       = 10,
    parameter int RF      = 16,
    parameter int W       = 16,
    parameter int MAX_CYC = 4096
) (
    input  wire             clk,
    input  wire             reset,
    run_sequencer_if.slave  bus
);
    localparam int AW = (RF > 1) ? $clog2(RF) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic          core_rst_q;
    logic          run_en_q;
    logic          rf_clr_en_q;
    logic [AW-1:0] rf_clr_addr_q;
    logic          done_q;
    logic          timeout_q;
    logic [W-1:0]  cycle_cnt_q;
    logic [D-1:0]  halt_pc_q;

    // Outputs are loaded together with the next state so every one is a flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            core_rst_q    <= 1'b1;
            run_en_q      <= 1'b0;
            rf_clr_en_q   <= 1'b0;
            rf_clr_addr_q <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_cnt_q   <= '0;
            halt_pc_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        state_q       <= CLEAR;
                        core_rst_q    <= 1'b1;
                        rf_clr_en_q   <= 1'b1;
                        rf_clr_addr_q <= '0;
                        cycle_cnt_q   <= '0;
                        timeout_q     <= 1'b0;
                        halt_pc_q     <= '0;
                    end
                end
                CLEAR: begin
                    if (!bus.req) begin
                        state_q       <= IDLE;
                        rf_clr_en_q   <= 1'b0;
                        rf_clr_addr_q <= '0;
                    end else if (rf_clr_addr_q == AW'(RF - 1)) begin
                        state_q       <= RUN;
                        rf_clr_en_q   <= 1'b0;
                        rf_clr_addr_q <= '0;
                        core_rst_q    <= 1'b0;
                        run_en_q      <= 1'b1;
                    end else begin
                        rf_clr_addr_q <= rf_clr_addr_q + 1'b1;
                    end
                end
                RUN: begin
                    cycle_cnt_q <= cycle_cnt_q + 1'b1;
                    if (!bus.req) begin
                        state_q    <= IDLE;
                        run_en_q   <= 1'b0;
                        core_rst_q <= 1'b1;
                    end else if (bus.halt) begin
                        state_q   <= DONE;
                        run_en_q  <= 1'b0;
                        done_q    <= 1'b1;
                        halt_pc_q <= bus.prog_ctr;
                    end else if (cycle_cnt_q == W'(MAX_CYC - 1)) begin
                        state_q   <= DONE;
                        run_en_q  <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.req) begin
                        state_q    <= IDLE;
                        done_q     <= 1'b0;
                        core_rst_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.core_rst    = core_rst_q;
    assign bus.run_en      = run_en_q;
    assign bus.rf_clr_en   = rf_clr_en_q;
    assign bus.rf_clr_addr = rf_clr_addr_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.halt_pc     = halt_pc_q;

endmodule

`default_nettype wire
